platform_pio_out: RTL and testbench

Avalon-MM slave output PIO: drives a WIDTH-bit `out_port` from a CPU-writable register, with atomic bit set/clear and a hardware-timed pulse generator. It is the write-direction counterpart to the platform's input PIO. It sits on the same lightweight bus segment, with the same zero-wait-state, one-cycle registered-read behaviour, so software can drive board-level strobes and enables without cycle-counting loops.

---
 rtl/platform_pio_out.sv | 148 ++++++++++++++
 tb/tb_platform_pio_out.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/platform_pio_out.sv
// platform_pio_out
// Avalon-MM slave output PIO. A CPU-writable base register drives out_port,
// with atomic bit set/clear and a hardware-timed pulse that inverts a
// selected set of bits for PULSE_LEN cycles.
//
// Ports:
//   clk, reset_n          system clock, asynchronous active-low reset
//   address[2:0]          word register index
//   chipselect, write_n   write strobe is chipselect & ~write_n
//   writedata[31:0]       write data
//   readdata[31:0]        registered read data (one cycle after address)
//   out_port[WIDTH-1:0]   registered output pins (base XOR active pulse mask)
//   pulse_busy            high exactly while a timed pulse is active
//
// Register map: 0 DATA (RW), 2 PULSE_LEN (RW), 3 STATUS (RO),
//               4 OUTSET (WO), 5 OUTCLEAR (WO), 6 PULSE (WO), 1/7 reserved.
module platform_pio_out #(
  parameter int                 WIDTH       = 16,
  parameter logic [WIDTH-1:0]   RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [WIDTH-1:0]  out_port,
  output logic              pulse_busy
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_PULSE = 1'b1
  } state_t;

  state_t             state_r;
  state_t             state_next_s;
  logic [WIDTH-1:0]   dreg_r;
  logic [WIDTH-1:0]   dreg_next_s;
  logic [WIDTH-1:0]   pmask_r;
  logic [WIDTH-1:0]   pmask_next_s;
  logic [15:0]        plen_r;
  logic [15:0]        plen_next_s;
  logic [15:0]        cnt_r;
  logic [15:0]        cnt_next_s;
  logic [WIDTH-1:0]   out_port_r;
  logic               pulse_busy_r;
  logic [31:0]        readdata_r;
  logic [31:0]        rd_next_s;
  logic               we_s;
  logic               unused_s;

  assign we_s     = chipselect & ~write_n;
  // Write data above bit 15 never reaches any register.
  assign unused_s = &{1'b0, writedata[31:16]};

  // Base register and pulse-length register next values from bus writes.
  always_comb begin
    dreg_next_s = dreg_r;
    plen_next_s = plen_r;
    if (we_s) begin
      case (address)
        3'd0:    dreg_next_s = writedata[WIDTH-1:0];
        3'd2:    plen_next_s = writedata[15:0];
        3'd4:    dreg_next_s = dreg_r | writedata[WIDTH-1:0];
        3'd5:    dreg_next_s = dreg_r & ~writedata[WIDTH-1:0];
        default: dreg_next_s = dreg_r;
      endcase
    end else begin
      dreg_next_s = dreg_r;
    end
  end

  // Pulse FSM next state: count down, then let a PULSE write override
  // (retrigger) so the new mask replaces the old one with no gap cycle.
  always_comb begin
    state_next_s = state_r;
    pmask_next_s = pmask_r;
    cnt_next_s   = cnt_r;
    case (state_r)
      ST_PULSE: begin
        if (cnt_r == 16'd1) begin
          state_next_s = ST_IDLE;
          pmask_next_s = {WIDTH{1'b0}};
          cnt_next_s   = 16'd0;
        end else begin
          cnt_next_s   = cnt_r - 16'd1;
        end
      end
      ST_IDLE: begin
        cnt_next_s = cnt_r;
      end
      default: begin
        state_next_s = ST_IDLE;
        pmask_next_s = {WIDTH{1'b0}};
        cnt_next_s   = 16'd0;
      end
    endcase
    // A zero-length trigger leaves the FSM exactly as it is.
    if (we_s && (address == 3'd6) && (plen_r != 16'd0)) begin
      state_next_s = ST_PULSE;
      pmask_next_s = writedata[WIDTH-1:0];
      cnt_next_s   = plen_r;
    end else begin
      cnt_next_s   = cnt_next_s;
    end
  end

  // Read mux; sampled every cycle regardless of chipselect.
  always_comb begin
    rd_next_s = 32'h0000_0000;
    case (address)
      3'd0:    rd_next_s = {{(32-WIDTH){1'b0}}, dreg_r};
      3'd2:    rd_next_s = {16'h0000, plen_r};
      3'd3:    rd_next_s = {cnt_r, 15'h0000, (state_r == ST_PULSE)};
      default: rd_next_s = 32'h0000_0000;
    endcase
  end

  // All architectural state and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      dreg_r       <= RESET_VALUE;
      pmask_r      <= {WIDTH{1'b0}};
      plen_r       <= 16'd1;
      cnt_r        <= 16'd0;
      out_port_r   <= RESET_VALUE;
      pulse_busy_r <= 1'b0;
      readdata_r   <= 32'h0000_0000;
    end else begin
      state_r      <= state_next_s;
      dreg_r       <= dreg_next_s;
      pmask_r      <= pmask_next_s;
      plen_r       <= plen_next_s;
      cnt_r        <= cnt_next_s;
      out_port_r   <= dreg_next_s ^ pmask_next_s;
      pulse_busy_r <= (state_next_s == ST_PULSE);
      readdata_r   <= rd_next_s;
    end
  end

  assign out_port   = out_port_r;
  assign pulse_busy = pulse_busy_r;
  assign readdata   = readdata_r;

endmodule

// File: tb/tb_platform_pio_out.sv
// Testbench for platform_pio_out (WIDTH = 16, RESET_VALUE = 0x00A5).
// Directed scenarios check spec constants; a randomized phase checks every
// cycle against a reference model that tracks pulses as "active until edge N".
module tb_platform_pio_out;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'h0;
  logic [31:0] readdata;
  logic [15:0] out_port;
  logic        pulse_busy;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int          cyc = 0;       // index of the last rising edge taken
  logic [15:0] m_dreg = 16'h00A5;
  logic [15:0] m_plen = 16'd1;
  logic [15:0] m_mask = 16'h0;
  int          m_end  = 0;    // pulse is active after edge e iff e < m_end
  logic [31:0] m_rd;
  logic [15:0] m_out;
  logic        m_busy;

  platform_pio_out #(.WIDTH(16), .RESET_VALUE(16'h00A5)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .out_port(out_port), .pulse_busy(pulse_busy)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_dreg = 16'h00A5;
    m_plen = 16'd1;
    m_mask = 16'h0;
    m_end  = cyc;
  endtask

  // Drive one bus cycle, take one edge, advance the model; returns #1 after edge.
  task automatic cycle(input logic cs, input logic wn, input logic [2:0] a,
                       input logic [31:0] wd);
    int e;
    bit act;
    logic [15:0] cntv;
    @(negedge clk);
    chipselect = cs; write_n = wn; address = a; writedata = wd;
    @(posedge clk);
    cyc++;
    e = cyc;
    act  = (e - 1) < m_end;
    cntv = act ? 16'(m_end - (e - 1)) : 16'd0;
    case (a)
      3'd0:    m_rd = {16'h0, m_dreg};
      3'd2:    m_rd = {16'h0, m_plen};
      3'd3:    m_rd = act ? {cntv, 15'h0, 1'b1} : 32'h0;
      default: m_rd = 32'h0;
    endcase
    if (cs && !wn) begin
      case (a)
        3'd0: m_dreg = wd[15:0];
        3'd2: m_plen = wd[15:0];
        3'd4: m_dreg = m_dreg | wd[15:0];
        3'd5: m_dreg = m_dreg & ~wd[15:0];
        3'd6: if (m_plen != 16'd0) begin m_mask = wd[15:0]; m_end = e + int'(m_plen); end
        default: ;
      endcase
    end
    act    = e < m_end;
    m_out  = m_dreg ^ (act ? m_mask : 16'h0);
    m_busy = act;
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    tests++; if (readdata !== 32'h0) begin fails++; $display("FAIL reset_readdata got=%h exp=%h", readdata, 32'h0); end
    tests++; if (out_port !== 16'h00A5) begin fails++; $display("FAIL reset_out got=%h exp=%h", out_port, 16'h00A5); end
    tests++; if (pulse_busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", pulse_busy); end
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    cycle(1'b0, 1'b1, 3'd2, 32'h0);
    tests++; if (readdata !== 32'h1) begin fails++; $display("FAIL reset_plen got=%h exp=%h", readdata, 32'h1); end
    cycle(1'b0, 1'b1, 3'd3, 32'h0);
    tests++; if (readdata !== 32'h0) begin fails++; $display("FAIL reset_status got=%h exp=%h", readdata, 32'h0); end
    tests++; if (out_port !== 16'h00A5) begin fails++; $display("FAIL reset_out_after got=%h exp=%h", out_port, 16'h00A5); end
  endtask

  task automatic test_set_clear();
    logic [15:0] exp_seq [3];
    logic [2:0]  adr_seq [3];
    logic [31:0] wd_seq  [3];
    exp_seq = '{16'h00F0, 16'h00FF, 16'h00CF};
    adr_seq = '{3'd0, 3'd4, 3'd5};
    wd_seq  = '{32'h00F0, 32'h000F, 32'h0030};
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, adr_seq[i], wd_seq[i]);
      tests++; if (out_port !== exp_seq[i]) begin fails++; $display("FAIL setclr_out[%0d] got=%h exp=%h", i, out_port, exp_seq[i]); end
    end
    cycle(1'b0, 1'b1, 3'd0, 32'h0);
    tests++; if (readdata !== 32'h00CF) begin fails++; $display("FAIL setclr_read_data got=%h exp=%h", readdata, 32'h00CF); end
    for (int a = 4; a <= 6; a++) begin
      cycle(1'b0, 1'b1, 3'(a), 32'h0);
      tests++; if (readdata !== 32'h0) begin fails++; $display("FAIL wo_read addr=%0d got=%h exp=0", a, readdata); end
    end
  endtask

  task automatic test_pulse_len();
    logic [31:0] exp_rd;
    cycle(1'b1, 1'b0, 3'd0, 32'h0000);
    cycle(1'b1, 1'b0, 3'd2, 32'd5);
    cycle(1'b1, 1'b0, 3'd6, 32'h0001);
    tests++; if (out_port !== 16'h0001 || pulse_busy !== 1'b1) begin fails++; $display("FAIL pulse_start out=%h busy=%b exp=0001/1", out_port, pulse_busy); end
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b1, 3'd3, 32'h0);
      exp_rd = (i < 5) ? {16'(5 - i), 15'h0, 1'b1} : 32'h0;
      tests++; if (readdata !== exp_rd) begin fails++; $display("FAIL pulse_status[%0d] got=%h exp=%h", i, readdata, exp_rd); end
      tests++; if (out_port !== ((i < 4) ? 16'h0001 : 16'h0000)) begin fails++; $display("FAIL pulse_out[%0d] got=%h", i, out_port); end
      tests++; if (pulse_busy !== (i < 4)) begin fails++; $display("FAIL pulse_busy[%0d] got=%b", i, pulse_busy); end
    end
  endtask

  task automatic test_retrigger();
    cycle(1'b1, 1'b0, 3'd2, 32'd10);
    cycle(1'b1, 1'b0, 3'd6, 32'h0003);
    tests++; if (out_port !== 16'h0003) begin fails++; $display("FAIL retrig_first got=%h exp=0003", out_port); end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 3'd0, 32'h0);
      tests++; if (out_port !== 16'h0003) begin fails++; $display("FAIL retrig_hold[%0d] got=%h exp=0003", i, out_port); end
    end
    cycle(1'b1, 1'b0, 3'd6, 32'h0100);
    tests++; if (out_port !== 16'h0100) begin fails++; $display("FAIL retrig_new got=%h exp=0100", out_port); end
    cycle(1'b1, 1'b0, 3'd0, 32'h0001);
    tests++; if (out_port !== 16'h0101) begin fails++; $display("FAIL retrig_base got=%h exp=0101", out_port); end
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, 3'd0, 32'h0);
      tests++; if (out_port !== 16'h0101 || pulse_busy !== 1'b1) begin fails++; $display("FAIL retrig_run[%0d] out=%h busy=%b exp=0101/1", i, out_port, pulse_busy); end
    end
    cycle(1'b0, 1'b1, 3'd0, 32'h0);
    tests++; if (out_port !== 16'h0001 || pulse_busy !== 1'b0) begin fails++; $display("FAIL retrig_end out=%h busy=%b exp=0001/0", out_port, pulse_busy); end
  endtask

  task automatic test_zero_len();
    cycle(1'b1, 1'b0, 3'd2, 32'd0);
    cycle(1'b1, 1'b0, 3'd6, 32'hFFFF);
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'b1, 3'd3, 32'h0);
      tests++; if (out_port !== 16'h0001 || pulse_busy !== 1'b0) begin fails++; $display("FAIL zero_len[%0d] out=%h busy=%b exp=0001/0", i, out_port, pulse_busy); end
    end
  endtask

  task automatic test_reset_mid_pulse();
    cycle(1'b1, 1'b0, 3'd2, 32'd100);
    cycle(1'b1, 1'b0, 3'd6, 32'h8000);
    for (int i = 0; i < 19; i++) cycle(1'b0, 1'b1, 3'd3, 32'h0);
    tests++; if (out_port !== 16'h8001 || pulse_busy !== 1'b1) begin fails++; $display("FAIL midrst_before out=%h busy=%b exp=8001/1", out_port, pulse_busy); end
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    tests++; if (out_port !== 16'h00A5 || pulse_busy !== 1'b0) begin fails++; $display("FAIL midrst_async out=%h busy=%b exp=00A5/0", out_port, pulse_busy); end
    tests++; if (readdata !== 32'h0) begin fails++; $display("FAIL midrst_readdata got=%h exp=0", readdata); end
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, 3'd3, 32'h0);
      tests++; if (out_port !== 16'h00A5 || pulse_busy !== 1'b0) begin fails++; $display("FAIL midrst_after[%0d] out=%h busy=%b", i, out_port, pulse_busy); end
    end
    tests++; if (readdata !== 32'h0) begin fails++; $display("FAIL midrst_status got=%h exp=0", readdata); end
  endtask

  task automatic test_random();
    logic        cs, wn;
    logic [2:0]  a;
    logic [31:0] wd;
    for (int i = 0; i < 400; i++) begin
      cs = ($urandom_range(0, 3) != 0);
      wn = ($urandom_range(0, 2) == 0);
      a  = 3'($urandom_range(0, 7));
      wd = $urandom;
      if (a == 3'd2) wd = {$urandom, 16'h0} | 32'($urandom_range(0, 7));
      cycle(cs, wn, a, wd);
      tests++; if (out_port !== m_out) begin fails++; $display("FAIL rand_out[%0d] got=%h exp=%h", i, out_port, m_out); end
      tests++; if (pulse_busy !== m_busy) begin fails++; $display("FAIL rand_busy[%0d] got=%b exp=%b", i, pulse_busy, m_busy); end
      tests++; if (readdata !== m_rd) begin fails++; $display("FAIL rand_rd[%0d] addr=%0d got=%h exp=%h", i, a, readdata, m_rd); end
    end
  endtask

  initial begin
    test_reset();
    test_set_clear();
    test_pulse_len();
    test_retrigger();
    test_zero_len();
    test_reset_mid_pulse();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
